pc_sel_ctrl: RTL

//   Next-PC controller: owns the PC register, resolves branch/jump/exception per cycle and drives
//   the 2-bit select plus the four candidate addresses into the next-PC 4:1 mux; takes the mux

---
 rtl/pc_sel_ctrl_pkg.sv | 25 ++
 rtl/pc_sel_ctrl_target_calc.sv | 21 ++
 rtl/pc_sel_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_sel_ctrl_pkg.sv
// Shared definitions for the next-PC controller: mux select codes,
// controller state encoding and the branch-condition helper.
package pc_sel_ctrl_pkg;

  // Next-PC mux select codes (input order of the external 4:1 mux)
  localparam logic [1:0] SEL_NEXT_INS = 2'b00;
  localparam logic [1:0] SEL_BRANCH   = 2'b01;
  localparam logic [1:0] SEL_JUMP     = 2'b10;
  localparam logic [1:0] SEL_ZERO     = 2'b11;

  // Controller state: BOOT only lasts the first cycle after reset
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } pc_state_e;

  // Conditional branch resolution for BEQ/BNE
  function automatic logic branch_taken(input logic is_beq,
                                        input logic is_bne,
                                        input logic rs_eq_rt);
    return (is_beq & rs_eq_rt) | (is_bne & ~rs_eq_rt);
  endfunction

endpackage

// File: rtl/pc_sel_ctrl_target_calc.sv
// Candidate next-PC address arithmetic (purely combinational, mod 2^32).
module pc_sel_ctrl_target_calc (
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  output logic [31:0] pc_add4,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target
);

  logic [31:0] branch_offset;

  // Sequential, PC-relative and region-absolute targets
  always_comb begin
    pc_add4       = pc + 32'd4;
    branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
    branch_target = pc_add4 + branch_offset;
    jump_target   = {pc_add4[31:28], instr_index, 2'b00};
  end

endmodule

// File: rtl/pc_sel_ctrl.sv
// Next-PC controller: owns the PC register, picks the next-PC mux input
// each cycle, registers the mux result and raises a one-cycle fetch flush
// after every redirect.
module pc_sel_ctrl
  import pc_sel_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        exc,
  input  logic        is_jump,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        rs_eq_rt,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic [31:0] pc_add4,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] exc_vector,
  output logic [1:0]  pc_sel,
  output logic        fetch_valid,
  output logic        flush
);

  pc_state_e state, state_next;
  logic      advance;

  pc_sel_ctrl_target_calc u_target_calc (
    .pc            (pc),
    .imm16         (imm16),
    .instr_index   (instr_index),
    .pc_add4       (pc_add4),
    .branch_target (branch_target),
    .jump_target   (jump_target)
  );

  assign exc_vector = EXC_VECTOR;

  // Select, advance and next-state decode; decode inputs only matter in RUN
  always_comb begin
    pc_sel      = SEL_NEXT_INS;
    state_next  = state;
    fetch_valid = 1'b0;
    advance     = 1'b0;

    if (exc) begin
      pc_sel = SEL_ZERO;
    end else if (state == ST_RUN) begin
      if (is_jump) begin
        pc_sel = SEL_JUMP;
      end else if (branch_taken(is_beq, is_bne, rs_eq_rt)) begin
        pc_sel = SEL_BRANCH;
      end
    end

    unique case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (exc) begin
          advance    = 1'b1;
          state_next = ST_RUN;
        end else if (stall || !imem_ready) begin
          state_next = ST_HOLD;
        end else begin
          advance    = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_HOLD: begin
        fetch_valid = 1'b1;
        if (exc) begin
          advance    = 1'b1;
          state_next = ST_RUN;
        end else if (!stall && imem_ready) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State, PC and flush registers; PC stays word aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      flush <= 1'b0;
    end else begin
      state <= state_next;
      flush <= advance && (pc_sel != SEL_NEXT_INS);
      if (advance) begin
        pc <= npc & ~32'h0000_0003;
      end
    end
  end

endmodule
